// File: rtl/polybius_pkg.sv
// Shared types, ASCII constants and the code-split helper for the Polybius
// digit serializer.
package polybius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TENS,
        ST_ONES,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_HASH = 8'h23;

    typedef struct packed {
        logic       err;
        logic [2:0] tens;
        logic [2:0] ones;
    } code_split_t;

    // Divider-free split: match the code against each of the five valid rows.
    function automatic code_split_t split_code(input logic [7:0] code);
        code_split_t res;
        logic [7:0]  base;
        logic [7:0]  diff;
        res = '{err: 1'b1, tens: '0, ones: '0};
        for (int unsigned t = 1; t <= 5; t++) begin
            base = 8'(t * 10);
            diff = code - base;
            if (code > base && diff <= 8'd5) begin
                res.err  = 1'b0;
                res.tens = 3'(t);
                res.ones = diff[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/polybius_code_decode.sv
// Combinational split of a Polybius code into its row/column digits plus an
// invalid-code flag.
module polybius_code_decode
    import polybius_pkg::*;
(
    input  logic [7:0] code_i,
    output logic [2:0] tens_o,
    output logic [2:0] ones_o,
    output logic       err_o
);

    code_split_t split;

    always_comb begin
        split  = split_code(code_i);
        tens_o = split.tens;
        ones_o = split.ones;
        err_o  = split.err;
    end

endmodule

// File: rtl/polybius_digit_serializer.sv
// Streams each accepted Polybius code as two ASCII digits followed by a space,
// or CR LF after the last code of a message; counts accepted and invalid codes.
module polybius_digit_serializer
    import polybius_pkg::*;
#(
    parameter logic [7:0]  SEP_CHAR = ASCII_SP,
    parameter logic [7:0]  ERR_CHAR = ASCII_HASH,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_code,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] err_count
);

    state_t             state_q, state_d;
    logic [2:0]         tens_q, ones_q;
    logic               err_q, last_q;
    logic [CNT_W-1:0]   char_cnt_q, err_cnt_q;

    logic [2:0]         dec_tens, dec_ones;
    logic               dec_err;
    logic               accept, out_hs;

    polybius_code_decode u_decode (
        .code_i (in_code),
        .tens_o (dec_tens),
        .ones_o (dec_ones),
        .err_o  (dec_err)
    );

    assign accept = in_valid && (state_q == ST_IDLE);
    assign out_hs = out_ready && (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_TENS;
            ST_TENS: if (out_hs) state_d = ST_ONES;
            ST_ONES: if (out_hs) state_d = last_q ? ST_CR : ST_SEP;
            ST_SEP:  if (out_hs) state_d = ST_IDLE;
            ST_CR:   if (out_hs) state_d = ST_LF;
            ST_LF:   if (out_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state and the held code, so they stay
    // stable for as long as the sink stalls.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q != ST_IDLE);
        out_last  = (state_q == ST_LF);
        out_char  = '0;
        case (state_q)
            ST_TENS: out_char = err_q ? ERR_CHAR : ASCII_ZERO + {5'b0, tens_q};
            ST_ONES: out_char = err_q ? ERR_CHAR : ASCII_ZERO + {5'b0, ones_q};
            ST_SEP:  out_char = SEP_CHAR;
            ST_CR:   out_char = ASCII_CR;
            ST_LF:   out_char = ASCII_LF;
            default: out_char = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
            err_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (accept) begin
            tens_q <= dec_tens;
            ones_q <= dec_ones;
            err_q  <= dec_err;
            last_q <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (accept) begin
            if (char_cnt_q != '1) char_cnt_q <= char_cnt_q + 1'b1;
            if (dec_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign char_count = char_cnt_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_polybius_digit_serializer.sv
// Self-checking bench for polybius_digit_serializer: cycle-exact table vectors,
// stall/reset corner sequences and a randomized stream against a byte model.
module tb_polybius_digit_serializer;

    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_code = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_char;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] char_count;
    logic [CW-1:0] err_count;

    logic rdy_manual = 1'b1;
    logic rdy_rand   = 1'b1;
    logic rand_mode  = 1'b0;
    assign out_ready = rand_mode ? rdy_rand : rdy_manual;

    polybius_digit_serializer #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_code    (in_code),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_char   (out_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .char_count (char_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rdy_rand <= ($urandom_range(0, 3) != 0);
    end

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int m_chars = 0;
    int m_errs  = 0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_char});
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: digits from plain decimal arithmetic on the code value.
    task automatic model_code(input int c, input bit last);
        int  t;
        int  o;
        bit  ok;
        t  = c / 10;
        o  = c % 10;
        ok = (t >= 1 && t <= 5 && o >= 1 && o <= 5);
        exp_q.push_back({1'b0, ok ? 8'(48 + t) : 8'h23});
        exp_q.push_back({1'b0, ok ? 8'(48 + o) : 8'h23});
        if (last) begin
            exp_q.push_back({1'b0, 8'h0D});
            exp_q.push_back({1'b1, 8'h0A});
        end else begin
            exp_q.push_back({1'b0, 8'h20});
        end
        m_chars++;
        if (!ok) m_errs++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        m_chars = 0;
        m_errs  = 0;
    endtask

    task automatic send(input int c, input bit last);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 0, 1);
        in_code  = 8'(c);
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        model_code(c, last);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!in_ready && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) check("idle_timeout", 0, 1);
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({name, "_byte"}, int'(got_q[i]), int'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]  code;
        bit          last;
        bit          err;
        int          n;
        logic [31:0] bytes;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int prev_c;
        int prev_e;
        logic [7:0] b;

        vecs[0] = '{8'd11, 1'b0, 1'b0, 3, 32'h3131_2000};
        vecs[1] = '{8'd24, 1'b1, 1'b0, 4, 32'h3234_0D0A};
        vecs[2] = '{8'd0,  1'b0, 1'b1, 3, 32'h2323_2000};
        vecs[3] = '{8'd16, 1'b0, 1'b1, 3, 32'h2323_2000};
        vecs[4] = '{8'd60, 1'b0, 1'b1, 3, 32'h2323_2000};
        vecs[5] = '{8'd55, 1'b1, 1'b0, 4, 32'h3535_0D0A};
        vecs[6] = '{8'd10, 1'b0, 1'b1, 3, 32'h2323_2000};
        vecs[7] = '{8'd51, 1'b0, 1'b0, 3, 32'h3531_2000};

        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_char", int'(out_char), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_char_count", int'(char_count), 0);
        check("rst_err_count", int'(err_count), 0);
        rst = 1'b0;
        tick();

        // Cycle-exact vectors; eight codes also drive the 3-bit counters into saturation.
        prev_c = 0;
        prev_e = 0;
        for (int v = 0; v < 8; v++) begin
            check("vec_in_ready", int'(in_ready), 1);
            in_code  = vecs[v].code;
            in_last  = vecs[v].last;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            prev_c = (prev_c < SAT) ? prev_c + 1 : SAT;
            if (vecs[v].err) prev_e = (prev_e < SAT) ? prev_e + 1 : SAT;
            check("vec_char_count", int'(char_count), prev_c);
            check("vec_err_count", int'(err_count), prev_e);
            for (int k = 0; k < vecs[v].n; k++) begin
                b = vecs[v].bytes[31 - 8 * k -: 8];
                check("vec_out_valid", int'(out_valid), 1);
                check("vec_out_char", int'(out_char), int'(b));
                check("vec_out_last", int'(out_last), (vecs[v].last && k == 3) ? 1 : 0);
                tick();
            end
            check("vec_back_idle", int'(in_ready), 1);
            check("vec_idle_valid", int'(out_valid), 0);
        end

        // Sink stall during the ONES beat of code 55.
        do_reset();
        in_code  = 8'd55;
        in_last  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        model_code(55, 0);
        check("stall_tens", int'(out_char), 8'h35);
        tick();
        rdy_manual = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_hold_char", int'(out_char), 8'h35);
            check("stall_hold_valid", int'(out_valid), 1);
            tick();
        end
        rdy_manual = 1'b1;
        wait_idle();
        compare_stream("stall_stream");

        // Reset in the middle of code 32 discards the partial group.
        do_reset();
        in_code  = 8'd32;
        in_last  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_char_count", int'(char_count), 0);
        check("midrst_err_count", int'(err_count), 0);
        got_q.delete();
        send(44, 0);
        wait_idle();
        compare_stream("midrst_stream");
        check("midrst_after_chars", int'(char_count), 1);

        // Message "AJZMT" with a randomly stalling sink.
        do_reset();
        rand_mode = 1'b1;
        send(11, 0);
        send(24, 0);
        send(55, 0);
        send(32, 0);
        send(44, 1);
        wait_idle();
        rand_mode = 1'b0;
        compare_stream("msg_stream");
        check("msg_char_count", int'(char_count), 5);
        check("msg_err_count", int'(err_count), 0);

        // Random codes (valid and invalid) against the model.
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 63)), ($urandom_range(0, 4) == 0));
        end
        wait_idle();
        rand_mode = 1'b0;
        compare_stream("rand_stream");
        check("rand_char_count", int'(char_count), (m_chars < SAT) ? m_chars : SAT);
        check("rand_err_count", int'(err_count), (m_errs < SAT) ? m_errs : SAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
